// File: rtl/vram_multiport.sv
// Multi-read-port word RAM with byte-enabled bus writes and a background fill engine.
// Storage is never cleared by reset; reset only clears read registers and the fill engine.
module vram_multiport #(
    parameter  int DEPTH   = 1200,
    parameter  int WORD_W  = 32,
    parameter  int NUM_RD  = 2,
    parameter  int RD_MODE = 0,
    localparam int AW      = $clog2(DEPTH),
    localparam int BE_W    = WORD_W / 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [AW-1:0]            wr_addr,
    input  logic [WORD_W-1:0]        wr_data,
    input  logic [BE_W-1:0]          byte_en,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*WORD_W-1:0] rd_data,
    input  logic                     fill_start,
    input  logic [WORD_W-1:0]        fill_data,
    output logic                     fill_busy,
    output logic                     fill_done,
    output logic [1:0]               dbg_fill_state
);

    localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } fill_state_t;

    // Fill handshake: fill_start is a one-cycle request, accepted only in IDLE.
    // fill_busy is high for every FILL cycle; fill_done is high for exactly the
    // single DONE cycle that follows the write of the last word. A bus write
    // (we=1) always wins the memory port and stalls the fill pointer.

    logic [WORD_W-1:0] r_mem [DEPTH];

    fill_state_t       r_state;
    fill_state_t       w_state_nxt;
    logic [AW-1:0]     r_fill_ptr;
    logic [AW-1:0]     w_fill_ptr_nxt;
    logic [WORD_W-1:0] r_fill_data;
    logic [WORD_W-1:0] w_fill_data_nxt;
    logic              w_fill_we;

    logic              w_bus_we;
    logic              w_mem_we;
    logic [AW-1:0]     w_mem_addr;
    logic [WORD_W-1:0] w_mem_data;
    logic [BE_W-1:0]   w_mem_be;
    logic [WORD_W-1:0] w_mem_mask;
    logic [WORD_W-1:0] w_mem_wdata;

    logic [AW-1:0]     w_rd_addr [NUM_RD];
    logic [WORD_W-1:0] w_rd_word [NUM_RD];

    // ------------------------------------------------------------------
    // Fill FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_fill_ptr  <= '0;
            r_fill_data <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_fill_ptr  <= w_fill_ptr_nxt;
            r_fill_data <= w_fill_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_fill_ptr_nxt  = r_fill_ptr;
        w_fill_data_nxt = r_fill_data;
        w_fill_we       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (fill_start) begin
                    w_state_nxt     = S_FILL;
                    w_fill_ptr_nxt  = '0;
                    w_fill_data_nxt = fill_data;
                end
            end
            S_FILL: begin
                if (!we) begin
                    w_fill_we = 1'b1;
                    if (r_fill_ptr == LAST_ADDR) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_fill_ptr_nxt = r_fill_ptr + 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign fill_busy      = (r_state == S_FILL);
    assign fill_done      = (r_state == S_DONE);
    assign dbg_fill_state = r_state;

    // ------------------------------------------------------------------
    // Single write port shared by bus and fill engine
    // ------------------------------------------------------------------
    assign w_bus_we   = we && ({1'b0, wr_addr} < DEPTH_W);
    assign w_mem_we   = w_bus_we || w_fill_we;
    assign w_mem_addr = we ? wr_addr : r_fill_ptr;
    assign w_mem_data = we ? wr_data : r_fill_data;
    assign w_mem_be   = we ? byte_en : {BE_W{1'b1}};

    always_comb begin
        w_mem_mask = '0;
        for (int b = 0; b < BE_W; b++) begin
            w_mem_mask[b*8 +: 8] = {8{w_mem_be[b]}};
        end
    end

    assign w_mem_wdata = (r_mem[w_mem_addr] & ~w_mem_mask) | (w_mem_data & w_mem_mask);

    // Contents survive reset; reset only blocks writes while it is asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
        end else if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            w_rd_addr[p] = rd_addr[p*AW +: AW];
            if ({1'b0, w_rd_addr[p]} >= DEPTH_W) begin
                w_rd_word[p] = '0;
            end else if ((RD_MODE == 1) && w_mem_we && (w_rd_addr[p] == w_mem_addr)) begin
                w_rd_word[p] = w_mem_wdata;
            end else begin
                w_rd_word[p] = r_mem[w_rd_addr[p]];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                rd_data[p*WORD_W +: WORD_W] <= w_rd_word[p];
            end
        end
    end

endmodule

// File: tb/tb_vram_multiport.sv
// Directed bench for vram_multiport: one read-first and one write-first instance share stimulus.
module tb_vram_multiport;

    localparam int DEPTH = 1200;
    localparam int AW    = 11;

    logic        clk;
    logic        rst;
    logic        we;
    logic [10:0] wr_addr;
    logic [31:0] wr_data;
    logic [3:0]  byte_en;
    logic [21:0] rd_addr;
    logic        fill_start;
    logic [31:0] fill_data;
    logic [63:0] rd_data0, rd_data1;
    logic        busy0, busy1, done0, done1;
    logic [1:0]  dbg0, dbg1;

    int n_checks = 0;
    int n_errors = 0;

    vram_multiport #(.DEPTH(DEPTH), .WORD_W(32), .NUM_RD(2), .RD_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .byte_en(byte_en), .rd_addr(rd_addr), .rd_data(rd_data0),
        .fill_start(fill_start), .fill_data(fill_data),
        .fill_busy(busy0), .fill_done(done0), .dbg_fill_state(dbg0)
    );

    vram_multiport #(.DEPTH(DEPTH), .WORD_W(32), .NUM_RD(2), .RD_MODE(1)) dut1 (
        .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .byte_en(byte_en), .rd_addr(rd_addr), .rd_data(rd_data1),
        .fill_start(fill_start), .fill_data(fill_data),
        .fill_busy(busy1), .fill_done(done1), .dbg_fill_state(dbg1)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks: all driving and sampling happens at the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [10:0] a, input logic [31:0] d, input logic [3:0] be);
        we = 1'b1; wr_addr = a; wr_data = d; byte_en = be;
        tick();
        we = 1'b0;
    endtask

    task automatic rd2(input logic [10:0] a0, input logic [10:0] a1);
        rd_addr = {a1, a0};
        tick();
    endtask

    // Runs one fill; optional bus writes at FILL cycles 3, 5, 6 and an ignored
    // second fill_start at cycle 10. Returns the cycle where fill_done is seen.
    task automatic run_fill(input logic [31:0] fd, input bit with_bus,
                            output int done_cyc, output logic busy_at1);
        int cyc;
        fill_data = fd; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        cyc = 1;
        busy_at1 = busy0;
        done_cyc = -1;
        while (cyc <= 1300 && done_cyc < 0) begin
            if (done0) begin
                done_cyc = cyc;
            end else begin
                if (with_bus && cyc == 3) begin we = 1'b1; wr_addr = 11'd1;   wr_data = 32'h0000_00B1; byte_en = 4'hF; end
                if (with_bus && cyc == 5) begin we = 1'b1; wr_addr = 11'd900; wr_data = 32'h0000_00B2; byte_en = 4'hF; end
                if (with_bus && cyc == 6) begin we = 1'b1; wr_addr = 11'd2;   wr_data = 32'h0000_00B3; byte_en = 4'hF; end
                if (cyc == 10) begin fill_start = 1'b1; fill_data = 32'h0000_0055; end
                tick();
                we = 1'b0; fill_start = 1'b0; fill_data = fd;
                cyc++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        we = 1'b1; wr_addr = 11'd3; wr_data = 32'hFFFF_FFFF; byte_en = 4'hF;
        fill_start = 1'b1; fill_data = 32'h1;
        rd_addr = '0;
        tick(); tick();
        n_checks++; if (rd_data0 !== 64'h0) begin n_errors++; $display("FAIL reset_rd_data: got %h want 0", rd_data0); end
        n_checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin n_errors++; $display("FAIL reset_flags: busy %b done %b want 0 0", busy0, done0); end
        n_checks++; if (dbg0 !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d want 0", dbg0); end
        we = 1'b0; fill_start = 1'b0;
        rst = 1'b1;
        tick();
        n_checks++; if (busy0 !== 1'b0 || dbg0 !== 2'd0) begin n_errors++; $display("FAIL reset_release_idle: busy %b state %0d want 0 0", busy0, dbg0); end
    endtask

    task automatic test_fill();
        int dc;
        logic b1;
        run_fill(32'h0000_0020, 1'b0, dc, b1);
        n_checks++; if (b1 !== 1'b1) begin n_errors++; $display("FAIL fill_busy_cycle1: got %b want 1", b1); end
        n_checks++; if (dc !== 1201) begin n_errors++; $display("FAIL fill_done_cycle: got %0d want 1201", dc); end
        n_checks++; if (busy0 !== 1'b0 || dbg0 !== 2'd2) begin n_errors++; $display("FAIL fill_done_state: busy %b state %0d want 0 2", busy0, dbg0); end
        tick();
        n_checks++; if (done0 !== 1'b0 || dbg0 !== 2'd0) begin n_errors++; $display("FAIL fill_done_pulse: done %b state %0d want 0 0", done0, dbg0); end
        rd2(11'd0, 11'd599);
        n_checks++; if (rd_data0 !== {32'h20, 32'h20}) begin n_errors++; $display("FAIL fill_rd_0_599: got %h want %h", rd_data0, {32'h20, 32'h20}); end
        rd2(11'd1199, 11'd1199);
        n_checks++; if (rd_data0 !== {32'h20, 32'h20}) begin n_errors++; $display("FAIL fill_rd_1199: got %h want %h", rd_data0, {32'h20, 32'h20}); end
        n_checks++; if (rd_data1 !== {32'h20, 32'h20}) begin n_errors++; $display("FAIL fill_rd_1199_wf: got %h want %h", rd_data1, {32'h20, 32'h20}); end
    endtask

    task automatic test_byte_enable();
        wr(11'd5, 32'h1122_3344, 4'hF);
        wr(11'd5, 32'hAABB_CCDD, 4'b0101);
        rd2(11'd5, 11'd5);
        n_checks++; if (rd_data0[31:0] !== 32'h11BB_33DD) begin n_errors++; $display("FAIL be_merge: got %h want 11bb33dd", rd_data0[31:0]); end
        n_checks++; if (rd_data0[63:32] !== 32'h11BB_33DD) begin n_errors++; $display("FAIL be_same_addr_p1: got %h want 11bb33dd", rd_data0[63:32]); end
        n_checks++; if (rd_data1 !== {32'h11BB_33DD, 32'h11BB_33DD}) begin n_errors++; $display("FAIL be_merge_wf: got %h want 11bb33dd11bb33dd", rd_data1); end
    endtask

    task automatic test_collision();
        wr(11'd7, 32'h0, 4'hF);
        rd_addr = {11'd5, 11'd7};
        wr(11'd7, 32'hDEAD_BEEF, 4'hF);
        n_checks++; if (rd_data0[31:0] !== 32'h0) begin n_errors++; $display("FAIL coll_read_first: got %h want 0", rd_data0[31:0]); end
        n_checks++; if (rd_data1[31:0] !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL coll_write_first: got %h want deadbeef", rd_data1[31:0]); end
        wr(11'd7, 32'h1234_5678, 4'b0011);
        n_checks++; if (rd_data0[31:0] !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL coll_be_read_first: got %h want deadbeef", rd_data0[31:0]); end
        n_checks++; if (rd_data1[31:0] !== 32'hDEAD_5678) begin n_errors++; $display("FAIL coll_be_write_first: got %h want dead5678", rd_data1[31:0]); end
        rd2(11'd7, 11'd7);
        n_checks++; if (rd_data0 !== {32'hDEAD_5678, 32'hDEAD_5678}) begin n_errors++; $display("FAIL coll_after: got %h want dead5678dead5678", rd_data0); end
    endtask

    task automatic test_out_of_range();
        wr(11'd1200, 32'hCAFE_F00D, 4'hF);
        rd2(11'd1200, 11'd2047);
        n_checks++; if (rd_data0 !== 64'h0) begin n_errors++; $display("FAIL oor_read: got %h want 0", rd_data0); end
        n_checks++; if (rd_data1 !== 64'h0) begin n_errors++; $display("FAIL oor_read_wf: got %h want 0", rd_data1); end
        rd2(11'd0, 11'd1199);
        n_checks++; if (rd_data0 !== {32'h20, 32'h20}) begin n_errors++; $display("FAIL oor_neighbours: got %h want %h", rd_data0, {32'h20, 32'h20}); end
    endtask

    task automatic test_fill_stall();
        int dc;
        logic b1;
        run_fill(32'h0000_0033, 1'b1, dc, b1);
        n_checks++; if (dc !== 1204) begin n_errors++; $display("FAIL stall_done_cycle: got %0d want 1204", dc); end
        tick();
        rd2(11'd1, 11'd2);
        n_checks++; if (rd_data0 !== {32'hB3, 32'hB1}) begin n_errors++; $display("FAIL stall_passed_words: got %h want %h", rd_data0, {32'hB3, 32'hB1}); end
        rd2(11'd900, 11'd3);
        n_checks++; if (rd_data0 !== {32'h33, 32'h33}) begin n_errors++; $display("FAIL stall_unpassed_words: got %h want %h", rd_data0, {32'h33, 32'h33}); end
        rd2(11'd0, 11'd1199);
        n_checks++; if (rd_data0 !== {32'h33, 32'h33}) begin n_errors++; $display("FAIL stall_ends: got %h want %h", rd_data0, {32'h33, 32'h33}); end
    endtask

    task automatic test_reset_mid_fill();
        int n_done;
        wr(11'd99, 32'h9999_9999, 4'hF);
        wr(11'd100, 32'h0BAD_CAFE, 4'hF);
        fill_data = 32'h0000_0077; fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        n_checks++; if (dbg0 !== 2'd1 || busy0 !== 1'b1) begin n_errors++; $display("FAIL midfill_before: state %0d busy %b want 1 1", dbg0, busy0); end
        rst = 1'b0;
        #1;
        n_checks++; if (busy0 !== 1'b0 || dbg0 !== 2'd0 || rd_data0 !== 64'h0) begin n_errors++; $display("FAIL midfill_async: busy %b state %0d rd %h want 0 0 0", busy0, dbg0, rd_data0); end
        we = 1'b1; wr_addr = 11'd200; wr_data = 32'hBAD0_BAD0; byte_en = 4'hF; fill_start = 1'b1;
        tick(); tick();
        we = 1'b0; fill_start = 1'b0;
        rst = 1'b1;
        n_done = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done0 || busy0) n_done++;
        end
        n_checks++; if (n_done !== 0) begin n_errors++; $display("FAIL midfill_no_done: got %0d active cycles want 0", n_done); end
        rd2(11'd0, 11'd99);
        n_checks++; if (rd_data0 !== {32'h77, 32'h77}) begin n_errors++; $display("FAIL midfill_written: got %h want %h", rd_data0, {32'h77, 32'h77}); end
        rd2(11'd100, 11'd101);
        n_checks++; if (rd_data0 !== {32'h33, 32'h0BAD_CAFE}) begin n_errors++; $display("FAIL midfill_unwritten: got %h want %h", rd_data0, {32'h33, 32'h0BAD_CAFE}); end
        rd2(11'd200, 11'd200);
        n_checks++; if (rd_data0 !== {32'h33, 32'h33}) begin n_errors++; $display("FAIL reset_blocks_write: got %h want %h", rd_data0, {32'h33, 32'h33}); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_byte_enable();
        test_collision();
        test_out_of_range();
        test_fill_stall();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vram_multiport.md
VRAM_MULTIPORT -- requirements
Module: vram_multiport

Interface
REQ-001 SHALL have parameter DEPTH, default 1200; number of words.
REQ-002 SHALL have parameter WORD_W, default 32; word width in bits, a multiple of 8.
REQ-003 SHALL have parameter NUM_RD, default 2; number of independent read ports, 1..4.
REQ-004 SHALL have parameter RD_MODE, default 0; 0 = read-first, 1 = write-first on same-address collision.
REQ-005 SHALL derive localparam AW = $clog2(DEPTH) and BE_W = WORD_W/8.
REQ-006 clk  input  1  the block's only clock, rising edge.
REQ-007 rst  input  1  reset, asynchronous and active-low.
REQ-008 we  input  1  bus write strobe.
REQ-009 wr_addr  input  AW  bus write word address.
REQ-010 wr_data  input  WORD_W  bus write data.
REQ-011 byte_en  input  BE_W  per-byte write enables; bit i gates wr_data[8i+7:8i].
REQ-012 rd_addr  input  NUM_RD*AW  packed read addresses; port p uses slice p.
REQ-013 rd_data  output  NUM_RD*WORD_W  packed registered read data; port p uses slice p.
REQ-014 fill_start  input  1  single-cycle request to fill all words with fill_data.
REQ-015 fill_data  input  WORD_W  fill value, sampled only in the cycle fill_start is accepted.
REQ-016 fill_busy  output  1  high while the fill engine owns pending writes.
REQ-017 fill_done  output  1  one-cycle pulse when a fill completes.

Function
REQ-018 Storage SHALL be DEPTH x WORD_W; contents SHALL NOT be cleared by reset (initialised to 0 for simulation only).
REQ-019 Bus write: when we=1 and wr_addr<DEPTH, each enabled byte SHALL update at the rising edge; disabled bytes SHALL hold.
REQ-020 A write with wr_addr>=DEPTH SHALL be dropped with no side effect.
REQ-021 Each read port SHALL have 1-cycle latency: rd_data[p] at edge N+1 = word at rd_addr[p] sampled at edge N.
REQ-022 A read with rd_addr[p]>=DEPTH SHALL return all zeros.
REQ-023 Same-address collision, RD_MODE=0: rd_data SHALL return the pre-write word.
REQ-024 Same-address collision, RD_MODE=1: rd_data SHALL return the post-write word (byte-merged); the same rule SHALL apply to fill writes.
REQ-025 Multiple read ports at the same address SHALL return identical data.
REQ-026 Fill FSM states: IDLE, FILL, DONE.
REQ-027 IDLE -> FILL on fill_start=1: latch fill_data, clear fill pointer to 0, assert fill_busy from the next cycle.
REQ-028 In FILL, each cycle with we=0 SHALL write the latched value (all bytes) at the pointer and increment the pointer.
REQ-029 In FILL, a cycle with we=1 SHALL perform the bus write only; the fill pointer SHALL stall (bus has priority).
REQ-030 FILL -> DONE after the write at pointer DEPTH-1; DONE SHALL pulse fill_done for one cycle, drop fill_busy, then return to IDLE.
REQ-031 fill_start while in FILL or DONE SHALL be ignored.
REQ-032 With no bus writes, a fill SHALL take exactly DEPTH cycles in FILL; fill_done SHALL assert on cycle DEPTH+1 after fill_start.
REQ-033 Reads SHALL remain fully functional during a fill.

Reset
REQ-034 On rst=0: rd_data=0, fill_busy=0, fill_done=0, FSM=IDLE, pointer=0, asynchronously.
REQ-035 Reset mid-fill SHALL abort the fill; already-written words SHALL keep the fill value, all others SHALL hold prior contents; no fill_done.
REQ-036 fill_start and we SHALL be ignored while rst=0.

Verification
REQ-037 Byte-enable merge: write 0x11223344 @5, then 0xAABBCCDD @5 with byte_en=0b0101 -> read @5 returns 0x11BB33DD after 1 cycle.
REQ-038 Collision: write 0xDEADBEEF @7 (prior 0) while rd_addr[0]=7 -> rd_data[0]=0 when RD_MODE=0, 0xDEADBEEF when RD_MODE=1.
REQ-039 Fill: fill_start with fill_data=0x00000020, DEPTH=1200, no bus writes -> fill_done pulses at cycle 1201; reads @0, @599, @1199 return 0x00000020.
REQ-040 Fill stall: 3 bus writes during a fill -> fill_done delayed exactly 3 cycles; written words hold the bus data only if written after the pointer passed them.
REQ-041 Out-of-range: write @1200 then read @1200 -> rd_data=0; words 0 and 1199 unchanged.
REQ-042 Reset mid-fill at pointer 100 -> fill_busy=0 immediately; words 0..99 hold the fill value, word 100 holds its old value; no fill_done.
